// File: rtl/dcache_wb.sv
// -----------------------------------------------------------------------------
// dcache_wb
//   Direct-mapped, write-back, write-allocate data cache. It sits between the
//   core's load/store uop stage and a slower backing memory. There is one
//   32-bit word per line, and all addresses are word addresses.
//
// Ports
//   clock      : single clock, rising edge
//   reset      : synchronous, active-high; invalidates every line and
//                abandons any miss in flight
//   addr       : word address of the core access
//   data_in    : store data
//   uop        : micro-op; only STR_UOP and LDR_UOP act, all others are no-ops
//   data_out   : registered load result
//   busy       : a miss is in progress; the core holds its inputs
//   mem_req    : backing-memory request, held until mem_ack
//   mem_we     : 1 = write-back of a dirty victim, 0 = refill read
//   mem_addr   : backing-memory word address
//   mem_wdata  : write-back data
//   mem_rdata  : refill data, valid together with mem_ack
//   mem_ack    : one-cycle acknowledge of the current request
// -----------------------------------------------------------------------------
module dcache_wb #(
    parameter int          ADDR_W  = 16,
    parameter int          INDEX_W = 4,
    parameter logic [4:0]  STR_UOP = 5'b01001,
    parameter logic [4:0]  LDR_UOP = 5'b01010
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    input  logic [4:0]        uop,
    output logic [31:0]       data_out,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    state_t state;

    // Line storage. The data and tag arrays carry no reset; the valid bits
    // alone decide whether a line means anything.
    logic [31:0]      data_mem [LINES];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;

    // The access that missed is captured here so the core inputs can be
    // ignored for the rest of the miss.
    logic              lat_str;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_data;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] lat_idx;
    logic [TAG_W-1:0]   lat_tag;
    logic               is_str;
    logic               is_ldr;
    logic               hit;
    logic               victim_dirty;
    logic               miss_start;

    assign idx     = addr[INDEX_W-1:0];
    assign tag     = addr[ADDR_W-1:INDEX_W];
    assign lat_idx = lat_addr[INDEX_W-1:0];
    assign lat_tag = lat_addr[ADDR_W-1:INDEX_W];
    assign is_str  = (uop == STR_UOP);
    assign is_ldr  = (uop == LDR_UOP);

    assign hit          = valid[idx] && (tag_mem[idx] == tag);
    assign victim_dirty = valid[idx] && dirty[idx];

    // A store miss onto a clean or invalid line is allocated in place. Only
    // load misses and dirty-victim store misses need the memory.
    assign miss_start = (state == IDLE) &&
                        ((is_ldr && !hit) || (is_str && !hit && victim_dirty));

    // Array write port. There are three writers: a store in IDLE, a latched
    // store that completes after its write-back, and refill data.
    logic               arr_we;
    logic [INDEX_W-1:0] arr_idx;
    logic [TAG_W-1:0]   arr_tag;
    logic [31:0]        arr_data;

    always_comb begin
        arr_we   = 1'b0;
        arr_idx  = idx;
        arr_tag  = tag;
        arr_data = data_in;
        case (state)
            IDLE: begin
                if (is_str && (hit || !victim_dirty)) begin
                    arr_we = 1'b1;
                end
            end
            WRITEBACK: begin
                if (mem_ack && lat_str) begin
                    arr_we   = 1'b1;
                    arr_idx  = lat_idx;
                    arr_tag  = lat_tag;
                    arr_data = lat_data;
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    arr_we   = 1'b1;
                    arr_idx  = lat_idx;
                    arr_tag  = lat_tag;
                    arr_data = mem_rdata;
                end
            end
            default: begin
                arr_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (arr_we) begin
            data_mem[arr_idx] <= arr_data;
            tag_mem[arr_idx]  <= arr_tag;
        end
    end

    // Control FSM and registered outputs. Reset wins over a coincident
    // mem_ack, so a write-back that was in flight is simply dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            data_out  <= '0;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_str   <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_ldr && hit) begin
                        data_out <= data_mem[idx];
                    end else if (is_str && (hit || !victim_dirty)) begin
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b1;
                    end else if (miss_start) begin
                        lat_str  <= is_str;
                        lat_addr <= addr;
                        lat_data <= data_in;
                        busy     <= 1'b1;
                        mem_req  <= 1'b1;
                        if (victim_dirty) begin
                            state     <= WRITEBACK;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_mem[idx], idx};
                            mem_wdata <= data_mem[idx];
                        end else begin
                            state    <= REFILL;
                            mem_we   <= 1'b0;
                            mem_addr <= addr;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        if (lat_str) begin
                            valid[lat_idx] <= 1'b1;
                            dirty[lat_idx] <= 1'b1;
                            busy           <= 1'b0;
                            mem_req        <= 1'b0;
                            mem_we         <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            // The refill is a second request. mem_req
                            // stays high while the request turns into a read.
                            mem_we   <= 1'b0;
                            mem_addr <= lat_addr;
                            state    <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        valid[lat_idx] <= 1'b1;
                        dirty[lat_idx] <= 1'b0;
                        data_out       <= mem_rdata;
                        busy           <= 1'b0;
                        mem_req        <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
